nco_upmixer: RTL and testbench
==============================

Name: nco_upmixer

Overview:
TX-path NCO upconverter. Mixes complex baseband samples by e^{+jθ[n]} before the DAC.
- Per IQ channel: 32-bit phase accumulator, quarter-wave sine LUT, complex multiplier, round/saturate to DAC_WIDTH.
- Sits between the TX baseband/interpolator output and the DAC interface; runs entirely in dac_clk.

Parameters:
IQCHANS, 1, number of independent IQ channels, each with its own accumulator and mixer
DAC_WIDTH, 12, signed output width per I/Q component (8..16)
LUT_AW, 10, quarter-wave LUT address bits; N = 2^LUT_AW

Ports:
dac_clk  in  1  clock
dac_rst  in  1  synchronous, active-high reset
in_data  in  IQCHANS*32  per channel {Q[15:0], I[15:0]}, signed Q1.15
in_valid  in  IQCHANS  per-channel sample strobe
cfg_phase_inc  in  IQCHANS*32  per-channel phase increment, 2^32 = one turn
cfg_phase_offset  in  IQCHANS*32  value loaded into the accumulator on cfg_phase_load
cfg_phase_load  in  IQCHANS  one-cycle pulse; loads the accumulator
dac_data  out  IQCHANS*2*DAC_WIDTH  per channel {Q, I}, signed two's complement
dac_valid  out  IQCHANS  aligned with dac_data

Behaviour:
- Reset: accumulators, all pipeline registers, dac_data and dac_valid are 0.
- Accumulator acc (per channel), evaluated each cycle:
  - if cfg_phase_load: acc <= cfg_phase_offset
  - else if in_valid: acc <= acc + cfg_phase_inc, mod 2^32 with silent wrap
- Phase used for a sample is acc before the update.
  - load and in_valid in the same cycle: that sample uses the pre-load acc; the next sample uses the offset.
- Phase index p = acc[31:30-LUT_AW]. Quadrant = p[LUT_AW+1:LUT_AW]; address a = p[LUT_AW-1:0].
- LUT: N+1 entries, LUT[k] = round(32767*sin(pi/2*k/N)), so LUT[0]=0 and LUT[N]=32767.
- sin by quadrant: q0 = LUT[a], q1 = LUT[N-a], q2 = -LUT[a], q3 = -LUT[N-a].
- cos = sin evaluated with quadrant+1 (mod 4).
- Pipeline, free-running, no stall; valid travels in a shift register, data registers update every cycle:
  - S1: register phase index and input sample
  - S2: LUT reads
  - S3: sign/quadrant fix
  - S4: four 16x16 signed products
  - S5: I' = xI*cos - xQ*sin; Q' = xI*sin + xQ*cos (33-bit)
  - S6: out = sat(floor((s + 2^(30-DAC_WIDTH)) >> (31-DAC_WIDTH))) to [-2^(DAC_WIDTH-1), 2^(DAC_WIDTH-1)-1]
- Latency: in_valid at cycle t gives dac_valid at t+6 for that sample. Gaps in in_valid are preserved exactly.
- dac_data holds its last value while dac_valid=0. No saturation counter and no sticky flags.
- Reset mid-stream: all in-flight samples are discarded and dac_valid is 0 from the next cycle.
- Channels are fully independent; channel i uses slice [32i+31:32i] of each cfg bus.

Optional Feature:
NCO_UPMIX_DITHER_EN
- Defined: per-channel 16-bit Galois LFSR (poly x^16+x^14+x^13+x^11+1, seed 0xACE1 + channel index), reset to seed, advances on in_valid. Its low (30-LUT_AW) bits are added to acc[29-LUT_AW:0] before truncation to p, for spur spreading. The accumulator itself is unaffected.
- Undefined: plain truncation; no LFSR logic.

Test Plan:
- inc=0, offset=0 via load, I=16384, Q=0 -> dac I=1024, Q=0, exactly 6 cycles after in_valid.
- inc=0x40000000, load 0, four consecutive samples I=16384, Q=0 -> (1024,0), (0,1024), (-1024,0), (0,-1024).
- I=32767, Q=32767, phase 0 -> I=2047 (saturated from 2048), Q=2047; I=-32768, Q=0 -> I=-2048.
- in_valid pattern 1,0,0,1,1 -> dac_valid replays 1,0,0,1,1 offset by 6 cycles; accumulator advances only 3 times.
- load offset 0x80000000 in the same cycle as a valid sample -> that sample uses the old phase; the next sample, I=16384, gives -1024.
- dac_rst asserted while 3 samples are in flight -> no dac_valid afterwards, dac_data=0, acc=0.

Source files
------------

// File: rtl/nco_upmixer.sv
// TX-path NCO upconverter: per-channel 32-bit phase accumulator, quarter-wave sine LUT,
// complex mixer by e^{+j*theta} and round/saturate to DAC_WIDTH. Optional phase dither: NCO_UPMIX_DITHER_EN.
module nco_upmixer #(
    parameter int IQCHANS   = 1,
    parameter int DAC_WIDTH = 12,
    parameter int LUT_AW    = 10
) (
    input  logic                           dac_clk,
    input  logic                           dac_rst,
    input  logic [IQCHANS*32-1:0]          in_data,
    input  logic [IQCHANS-1:0]             in_valid,
    input  logic [IQCHANS*32-1:0]          cfg_phase_inc,
    input  logic [IQCHANS*32-1:0]          cfg_phase_offset,
    input  logic [IQCHANS-1:0]             cfg_phase_load,
    output logic [IQCHANS*2*DAC_WIDTH-1:0] dac_data,
    output logic [IQCHANS-1:0]             dac_valid
);
    localparam int LUT_N = 1 << LUT_AW;
    localparam int PW    = LUT_AW + 2;
    localparam int FW    = 30 - LUT_AW;
    localparam logic [LUT_AW:0]    LUT_TOP  = (LUT_AW + 1)'(LUT_N);
    localparam logic signed [33:0] RND_BIAS = 34'sd1 <<< (30 - DAC_WIDTH);
    localparam logic signed [33:0] SAT_MAX  = (34'sd1 <<< (DAC_WIDTH - 1)) - 34'sd1;
    localparam logic signed [33:0] SAT_MIN  = -(34'sd1 <<< (DAC_WIDTH - 1));

    function automatic logic [15:0] lut_calc(input int k);
        real ang;
        real val;
        ang = 1.5707963267948966 * real'(k) / real'(LUT_N);
        val = 32767.0 * $sin(ang) + 0.5;
        return 16'($rtoi(val));
    endfunction

    // Odd quadrants read the table mirrored about the quarter-wave point.
    function automatic logic [LUT_AW:0] lut_addr(input logic [1:0] quad, input logic [LUT_AW-1:0] a);
        logic [LUT_AW:0] addr;
        if (quad[0]) begin
            addr = LUT_TOP - {1'b0, a};
        end else begin
            addr = {1'b0, a};
        end
        return addr;
    endfunction

    function automatic logic [DAC_WIDTH-1:0] sat_round(input logic signed [32:0] s);
        logic signed [33:0]   biased;
        logic signed [33:0]   shifted;
        logic [DAC_WIDTH-1:0] res;
        biased  = 34'(s) + RND_BIAS;
        shifted = biased >>> (31 - DAC_WIDTH);
        if (shifted > SAT_MAX) begin
            res = SAT_MAX[DAC_WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[DAC_WIDTH-1:0];
        end else begin
            res = shifted[DAC_WIDTH-1:0];
        end
        return res;
    endfunction

    logic [15:0] lut_rom [0:LUT_N];
    for (genvar k = 0; k <= LUT_N; k++) begin : g_lut
        localparam logic [15:0] LUT_VAL = lut_calc(k);
        assign lut_rom[k] = LUT_VAL;
    end

    for (genvar c = 0; c < IQCHANS; c++) begin : g_chan
        logic [31:0]          inc_s;
        logic [31:0]          off_s;
        logic signed [15:0]   xi_s;
        logic signed [15:0]   xq_s;
        logic [31:0]          acc_r;
        logic [PW-1:0]        phase_s;
        logic [PW-1:0]        s1_phase_r;
        logic signed [15:0]   s1_xi_r;
        logic signed [15:0]   s1_xq_r;
        logic [1:0]           s1_quad_s;
        logic [LUT_AW:0]      sin_addr_s;
        logic [LUT_AW:0]      cos_addr_s;
        logic [1:0]           s2_quad_r;
        logic [1:0]           s2_cos_quad_s;
        logic [15:0]          s2_sin_r;
        logic [15:0]          s2_cos_r;
        logic signed [15:0]   s2_xi_r;
        logic signed [15:0]   s2_xq_r;
        logic signed [15:0]   s3_sin_r;
        logic signed [15:0]   s3_cos_r;
        logic signed [15:0]   s3_xi_r;
        logic signed [15:0]   s3_xq_r;
        logic signed [31:0]   s4_ii_r;
        logic signed [31:0]   s4_qs_r;
        logic signed [31:0]   s4_is_r;
        logic signed [31:0]   s4_qc_r;
        logic signed [32:0]   s5_i_r;
        logic signed [32:0]   s5_q_r;
        logic [5:1]           vld_r;
        logic [DAC_WIDTH-1:0] out_i_r;
        logic [DAC_WIDTH-1:0] out_q_r;
        logic                 out_valid_r;

        assign inc_s = cfg_phase_inc[c*32 +: 32];
        assign off_s = cfg_phase_offset[c*32 +: 32];
        assign xi_s  = in_data[c*32 +: 16];
        assign xq_s  = in_data[c*32+16 +: 16];

`ifdef NCO_UPMIX_DITHER_EN
        localparam logic [15:0] SEED  = 16'hACE1 + 16'(c);
        localparam logic [31:0] DMASK = (32'd1 << FW) - 32'd1;
        logic [15:0] lfsr_r;
        logic [31:0] dith_acc_s;

        // Galois LFSR x^16+x^14+x^13+x^11+1, one step per accepted sample
        always_ff @(posedge dac_clk) begin
            if (dac_rst) begin
                lfsr_r <= SEED;
            end else if (in_valid[c]) begin
                lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
            end else begin
                lfsr_r <= lfsr_r;
            end
        end

        // Dither perturbs only the LUT index; the accumulator itself stays exact.
        assign dith_acc_s = acc_r + ({16'h0000, lfsr_r} & DMASK);
        assign phase_s    = dith_acc_s[31:FW];
`else
        assign phase_s = acc_r[31:FW];
`endif

        // Phase accumulator; load wins over increment, samples see the pre-update value
        always_ff @(posedge dac_clk) begin
            if (dac_rst) begin
                acc_r <= 32'd0;
            end else if (cfg_phase_load[c]) begin
                acc_r <= off_s;
            end else if (in_valid[c]) begin
                acc_r <= acc_r + inc_s;
            end else begin
                acc_r <= acc_r;
            end
        end

        assign s1_quad_s     = s1_phase_r[PW-1:PW-2];
        assign sin_addr_s    = lut_addr(s1_quad_s, s1_phase_r[LUT_AW-1:0]);
        assign cos_addr_s    = lut_addr(s1_quad_s + 2'd1, s1_phase_r[LUT_AW-1:0]);
        assign s2_cos_quad_s = s2_quad_r + 2'd1;

        // Free-running datapath S1..S5 plus the valid shift register
        always_ff @(posedge dac_clk) begin
            if (dac_rst) begin
                vld_r      <= 5'd0;
                s1_phase_r <= '0;
                s1_xi_r    <= 16'sd0;
                s1_xq_r    <= 16'sd0;
                s2_quad_r  <= 2'd0;
                s2_sin_r   <= 16'd0;
                s2_cos_r   <= 16'd0;
                s2_xi_r    <= 16'sd0;
                s2_xq_r    <= 16'sd0;
                s3_sin_r   <= 16'sd0;
                s3_cos_r   <= 16'sd0;
                s3_xi_r    <= 16'sd0;
                s3_xq_r    <= 16'sd0;
                s4_ii_r    <= 32'sd0;
                s4_qs_r    <= 32'sd0;
                s4_is_r    <= 32'sd0;
                s4_qc_r    <= 32'sd0;
                s5_i_r     <= 33'sd0;
                s5_q_r     <= 33'sd0;
            end else begin
                vld_r      <= {vld_r[4:1], in_valid[c]};
                s1_phase_r <= phase_s;
                s1_xi_r    <= xi_s;
                s1_xq_r    <= xq_s;
                s2_quad_r  <= s1_quad_s;
                s2_sin_r   <= lut_rom[sin_addr_s];
                s2_cos_r   <= lut_rom[cos_addr_s];
                s2_xi_r    <= s1_xi_r;
                s2_xq_r    <= s1_xq_r;
                s3_sin_r   <= s2_quad_r[1] ? (16'd0 - s2_sin_r) : s2_sin_r;
                s3_cos_r   <= s2_cos_quad_s[1] ? (16'd0 - s2_cos_r) : s2_cos_r;
                s3_xi_r    <= s2_xi_r;
                s3_xq_r    <= s2_xq_r;
                s4_ii_r    <= 32'(s3_xi_r) * 32'(s3_cos_r);
                s4_qs_r    <= 32'(s3_xq_r) * 32'(s3_sin_r);
                s4_is_r    <= 32'(s3_xi_r) * 32'(s3_sin_r);
                s4_qc_r    <= 32'(s3_xq_r) * 32'(s3_cos_r);
                s5_i_r     <= 33'(s4_ii_r) - 33'(s4_qs_r);
                s5_q_r     <= 33'(s4_is_r) + 33'(s4_qc_r);
            end
        end

        // Output stage: data holds between valid samples
        always_ff @(posedge dac_clk) begin
            if (dac_rst) begin
                out_valid_r <= 1'b0;
                out_i_r     <= '0;
                out_q_r     <= '0;
            end else if (vld_r[5]) begin
                out_valid_r <= 1'b1;
                out_i_r     <= sat_round(s5_i_r);
                out_q_r     <= sat_round(s5_q_r);
            end else begin
                out_valid_r <= 1'b0;
                out_i_r     <= out_i_r;
                out_q_r     <= out_q_r;
            end
        end

        assign dac_data[c*2*DAC_WIDTH +: 2*DAC_WIDTH] = {out_q_r, out_i_r};
        assign dac_valid[c]                          = out_valid_r;
    end
endmodule

// File: tb/tb_nco_upmixer.sv
// Scoreboard bench for nco_upmixer: directed samples push expected {I,Q,cycle}; a negedge monitor pops and compares.
module tb_nco_upmixer;
    localparam int DW = 12;

    logic          dac_clk = 1'b0;
    logic          dac_rst;
    logic [31:0]   in_data;
    logic [0:0]    in_valid;
    logic [31:0]   cfg_phase_inc;
    logic [31:0]   cfg_phase_offset;
    logic [0:0]    cfg_phase_load;
    logic [2*DW-1:0] dac_data;
    logic [0:0]    dac_valid;

    typedef struct {
        logic signed [DW-1:0] ei;
        logic signed [DW-1:0] eq;
        int                   cyc;
        string                nm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic signed [DW-1:0] rot_i [4];
    logic signed [DW-1:0] rot_q [4];

    nco_upmixer #(.IQCHANS(1), .DAC_WIDTH(DW), .LUT_AW(10)) dut (
        .dac_clk          (dac_clk),
        .dac_rst          (dac_rst),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .cfg_phase_inc    (cfg_phase_inc),
        .cfg_phase_offset (cfg_phase_offset),
        .cfg_phase_load   (cfg_phase_load),
        .dac_data         (dac_data),
        .dac_valid        (dac_valid)
    );

    always #5 dac_clk = ~dac_clk;

    always @(posedge dac_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic step(input logic v, input logic ld, input logic [31:0] off,
                        input logic signed [15:0] xi, input logic signed [15:0] xq);
        @(negedge dac_clk);
        in_valid         = v;
        cfg_phase_load   = ld;
        cfg_phase_offset = off;
        in_data          = {xq, xi};
    endtask

    task automatic expect_out(input logic signed [DW-1:0] ei, input logic signed [DW-1:0] eq, input string nm);
        exp_t e;
        e.ei  = ei;
        e.eq  = eq;
        e.cyc = cyc + 6;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 16'sd0, 16'sd0);
    endtask

    // Monitor: every dac_valid must match the oldest expectation, in value and in cycle
    always @(negedge dac_clk) begin
        if (dac_valid[0] === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.nm, "_i"}, $signed(dac_data[DW-1:0]), mon_e.ei);
                check({mon_e.nm, "_q"}, $signed(dac_data[2*DW-1:DW]), mon_e.eq);
                check({mon_e.nm, "_cycle"}, cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        rot_i = '{12'sd1024, 12'sd0, -12'sd1024, 12'sd0};
        rot_q = '{12'sd0, 12'sd1024, 12'sd0, -12'sd1024};
        dac_rst          = 1'b1;
        in_valid         = 1'b0;
        cfg_phase_load   = 1'b0;
        cfg_phase_inc    = 32'h0;
        cfg_phase_offset = 32'h0;
        in_data          = 32'h0;
        repeat (4) @(negedge dac_clk);
        check("reset_valid", dac_valid, 0);
        check("reset_data", dac_data, 0);
        dac_rst = 1'b0;
        idle(2);

        step(1'b0, 1'b1, 32'h0, 16'sd0, 16'sd0);
        step(1'b1, 1'b0, 32'h0, 16'sd16384, 16'sd0);
        expect_out(12'sd1024, 12'sd0, "unity");
        idle(2);

        cfg_phase_inc = 32'h4000_0000;
        step(1'b0, 1'b1, 32'h0, 16'sd0, 16'sd0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 32'h0, 16'sd16384, 16'sd0);
            expect_out(rot_i[k], rot_q[k], $sformatf("quarter%0d", k));
        end
        idle(2);

        cfg_phase_inc = 32'h0;
        step(1'b0, 1'b1, 32'h4000_0000, 16'sd0, 16'sd0);
        step(1'b1, 1'b0, 32'h0, 16'sd0, 16'sd16384);
        expect_out(-12'sd1024, 12'sd0, "q_in_rot90");
        idle(2);

        step(1'b0, 1'b1, 32'h2000_0000, 16'sd0, 16'sd0);
        step(1'b1, 1'b0, 32'h0, 16'sd16384, 16'sd0);
        expect_out(12'sd724, 12'sd724, "rot45");
        idle(2);

        step(1'b0, 1'b1, 32'h0, 16'sd0, 16'sd0);
        step(1'b1, 1'b0, 32'h0, 16'sd32767, 16'sd32767);
        expect_out(12'sd2047, 12'sd2047, "sat_pos");
        step(1'b1, 1'b0, 32'h0, 16'h8000, 16'sd0);
        expect_out(12'h800, 12'sd0, "neg_full");
        idle(2);

        cfg_phase_inc = 32'h4000_0000;
        step(1'b0, 1'b1, 32'h0, 16'sd0, 16'sd0);
        step(1'b1, 1'b0, 32'h0, 16'sd16384, 16'sd0);
        expect_out(12'sd1024, 12'sd0, "gap0");
        idle(2);
        step(1'b1, 1'b0, 32'h0, 16'sd16384, 16'sd0);
        expect_out(12'sd0, 12'sd1024, "gap3");
        step(1'b1, 1'b0, 32'h0, 16'sd16384, 16'sd0);
        expect_out(-12'sd1024, 12'sd0, "gap4");
        idle(2);

        step(1'b0, 1'b1, 32'h0, 16'sd0, 16'sd0);
        step(1'b1, 1'b1, 32'h8000_0000, 16'sd16384, 16'sd0);
        expect_out(12'sd1024, 12'sd0, "load_same_old");
        step(1'b1, 1'b0, 32'h0, 16'sd16384, 16'sd0);
        expect_out(-12'sd1024, 12'sd0, "load_same_new");
        idle(10);

        cfg_phase_inc = 32'h1234_5678;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 16'sd16384, 16'sd8000);
        @(negedge dac_clk);
        dac_rst  = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge dac_clk);
        dac_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge dac_clk);
            check("flush_valid", dac_valid, 0);
            check("flush_data", dac_data, 0);
        end
        cfg_phase_inc = 32'h0;
        step(1'b1, 1'b0, 32'h0, 16'sd16384, 16'sd0);
        expect_out(12'sd1024, 12'sd0, "post_rst_acc0");
        idle(1);

        for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge dac_clk);
        check("drain_pending", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
